// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the fifo_drain read-side agent.
package fifo_drain_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

  typedef logic [OCC_W-1:0] occ_t;

endpackage

// File: rtl/fifo_drain_if.sv
// FIFO read port (e/RD/RREQ) plus the valid/ready output stream of fifo_drain.
interface fifo_drain_if #(
  parameter int DW = 8
);
  logic          e;
  logic [DW-1:0] RD;
  logic          RREQ;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;

  modport master (
    input  e, RD, out_ready,
    output RREQ, out_valid, out_data
  );

  modport slave (
    output e, RD, out_ready,
    input  RREQ, out_valid, out_data
  );
endinterface

// File: rtl/fifo_drain_buf.sv
// Two-entry FIFO-ordered skid buffer that absorbs the FIFO's one-cycle read latency.
module fifo_drain_buf
  import fifo_drain_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] head,
  output occ_t          occ
);

  logic [DW-1:0] slot0;
  logic [DW-1:0] slot1;

  // NOTE: the two data slots are reset as well, so out_data reads 0 after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0 <= '0;
      slot1 <= '0;
      occ   <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (occ == '0) slot0 <= push_data;
          else           slot1 <= push_data;
          occ <= occ + occ_t'(1);
        end
        2'b01: begin
          slot0 <= slot1;
          occ   <= occ - occ_t'(1);
        end
        2'b11: begin
          // Simultaneous pop and capture: occupancy holds, order is kept.
          if (occ == occ_t'(1)) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = slot0;

endmodule

// File: rtl/fifo_drain.sv
// Read-side agent for the single-clock fifo: FSM, read credit logic and optional
// statistics counters (enabled with FIFO_DRAIN_STATS_EN).
module fifo_drain
  import fifo_drain_pkg::*;
#(
  parameter int DW = 8
`ifdef FIFO_DRAIN_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  fifo_drain_if.master     bus,
  output logic             busy
`ifdef FIFO_DRAIN_STATS_EN
  , output logic [CNT_W-1:0] rd_count
  , output logic [CNT_W-1:0] stall_count
`endif
);

  state_t         state;
  logic           inflight;
  logic           pop;
  logic           rreq;
  occ_t           occ;
  logic [OCC_W:0] used;

  assign pop = bus.out_valid & bus.out_ready;

  // NOTE: every signal written here gets a default first, so no latch can form.
  always_comb begin
    used = {1'b0, occ} + (OCC_W + 1)'(inflight) - (OCC_W + 1)'(pop);
    rreq = 1'b0;
    if (state == RUN && !bus.e && used < (OCC_W + 1)'(BUF_DEPTH)) rreq = 1'b1;
  end

  assign bus.RREQ = rreq;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      inflight <= 1'b0;
    end else begin
      inflight <= rreq;
      unique case (state)
        IDLE:    if (en) state <= RUN;
        RUN:     if (!en) state <= STOP;
        STOP: begin
          if (en)                             state <= RUN;
          else if (!inflight && occ == '0)    state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fifo_drain_buf #(.DW(DW)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (bus.RD),
    .pop       (pop),
    .head      (bus.out_data),
    .occ       (occ)
  );

  assign bus.out_valid = (occ != '0);
  assign busy          = (state != IDLE) || inflight || (occ != '0);

`ifdef FIFO_DRAIN_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count    <= '0;
      stall_count <= '0;
    end else begin
      if (rreq && rd_count != '1)
        rd_count <= rd_count + CNT_W'(1);
      if (bus.out_valid && !bus.out_ready && stall_count != '1)
        stall_count <= stall_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/fifo_drain.md
# fifo_drain

Read-side agent for the single-clock `fifo`. It pops words through the FIFO's RREQ/RD/e read port and absorbs the one-cycle read latency in a 2-entry output buffer. It presents the words on a valid/ready stream. It sits between the FIFO read port and any downstream consumer, and is the read-side counterpart of the write traffic driven into WREQ/WD.

## Interface
Parameters:
- DW, 8: data width; must match the FIFO's WD/RD width.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  single clock; the FIFO's clkr is tied to the same net.
- rst  in  1  reset; asynchronous, active-high.
- en  in  1  drain enable.
- e  in  1  FIFO empty flag.
- RD  in  DW  FIFO read data; valid in the cycle after RREQ.
- RREQ  out  1  FIFO read request; combinational.
- out_valid  out  1  output word available.
- out_data  out  DW  output word.
- out_ready  in  1  consumer accepts the word.
- busy  out  1  state != IDLE, or a read is in flight, or the buffer is non-empty.
- rd_count  out  CNT_W  words popped from the FIFO; present only with FIFO_DRAIN_STATS_EN.
- stall_count  out  CNT_W  cycles with out_valid=1 and out_ready=0; present only with FIFO_DRAIN_STATS_EN.

## Operation
- State machine, states IDLE, RUN, STOP:
  - IDLE -> RUN when en=1.
  - RUN -> STOP when en=0.
  - STOP -> IDLE when inflight=0 and buffer empty.
  - STOP -> RUN when en=1.
- Read request: RREQ = (state==RUN) & ~e & (occ + inflight - pop < 2).
  - pop = out_valid & out_ready.
  - occ is the buffer occupancy (0..2).
  - inflight is a 1-bit register set by RREQ.
- RREQ is never asserted while e=1, so no underflow is possible.
- The FIFO updates e at the same edge that consumes RREQ, so RREQ on back-to-back cycles is legal.
- Capture: when inflight=1, RD is written into the buffer at the next edge.
- Buffer: 2-entry FIFO-ordered buffer.
  - out_data is the head entry.
  - out_valid = (occ != 0).
  - Capture and pop in the same cycle leave occ unchanged; order is preserved.
- The credit check guarantees no overflow. A capture into a full buffer is impossible; the bench asserts this.
- Deasserting en does not drop data. In-flight words and buffered words are still delivered in STOP.
- Reset mid-operation clears state, inflight, buffer and counters. A word in flight at reset is discarded.

## Timing
- Reset values:
  - RREQ=0 whenever state=IDLE; state=IDLE.
  - out_valid=0, out_data=0, busy=0, rd_count=0, stall_count=0.
- Read latency: RREQ in cycle N, RD valid in cycle N+1, out_valid=1 in cycle N+2.
- Throughput: with out_ready held high and e=0, one word per cycle after a 2-cycle fill.
- e falls in cycle M with state=RUN: RREQ rises in cycle M (combinational).
- en falls in cycle K: no RREQ from cycle K+1 onward. The last in-flight word appears by cycle K+2. busy falls after the final pop.

## Configuration
- FIFO_DRAIN_STATS_EN defined:
  - rd_count increments on each RREQ.
  - stall_count increments on each stalled cycle.
  - Both counters saturate at all-ones.
- FIFO_DRAIN_STATS_EN undefined: the rd_count and stall_count ports and their logic are absent. All other behaviour is identical.

## Structure
- Package fifo_drain_pkg holds:
  - the state enum (IDLE, RUN, STOP);
  - the constant BUF_DEPTH=2;
  - the occupancy width.
- Sub-module fifo_drain_buf holds the 2-entry buffer, with ports: push, push_data, pop, head, occ.
- The top level holds the FSM, credit logic and the optional counters.

## Test plan
- Reset and idle:
  - Stimulus: rst pulsed for 1 ns; FIFO pre-loaded with 0x11,0x22,0x33; en=0.
  - Response: RREQ=0, out_valid=0, busy=0 for 20 cycles.
- Streaming:
  - Stimulus: en=1, out_ready=1, FIFO holds 0x11,0x22,0x33.
  - Response: out_data 0x11,0x22,0x33 on consecutive cycles, starting 2 cycles after the first RREQ. e rises and RREQ stays 0 afterwards.
- Backpressure:
  - Stimulus: out_ready=0 with 5 words queued.
  - Response: exactly 2 RREQ pulses, then RREQ=0. out_data holds 0x11. stall_count counts every stalled cycle.
  - Stimulus: release out_ready.
  - Response: remaining words arrive in order with no gaps.
- Stop mid-stream:
  - Stimulus: deassert en in the same cycle as an RREQ.
  - Response: the in-flight word is still delivered; state STOP -> IDLE; busy falls; no further RREQ.
- Interleaved write:
  - Stimulus: a single word written while the FIFO is empty.
  - Response: RREQ in the cycle e falls; word out 2 cycles later; rd_count=1.
- Async reset:
  - Stimulus: rst asserted while occ=2.
  - Response: out_valid=0 immediately, before the next clk edge; counters read 0.
